// File: rtl/ibex_rf_pkg.sv
// Shared register-file definitions: address type, register count helper and port-count limits.
package ibex_rf_pkg;

  typedef logic [4:0] rf_addr_t;

  localparam int MaxReadPorts  = 4;
  localparam int MaxWritePorts = 2;

  function automatic int num_regs(input bit rv32e);
    return rv32e ? 16 : 32;
  endfunction

endpackage

// File: rtl/ibex_rf_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set by alloc and cleared by writes.
module ibex_rf_scoreboard
  import ibex_rf_pkg::*;
#(
  parameter int NumRegs      = 32,
  parameter int NumReadPorts = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alloc_i,
  input  rf_addr_t                  alloc_addr_i,
  input  logic [NumRegs-1:0]        clr_i,
  input  logic [5*NumReadPorts-1:0] raddr_i,
  output logic [NumReadPorts-1:0]   pend_o
);

  localparam int AddrW = $clog2(NumRegs);

  logic [NumRegs-1:0] pend_q;
  logic [NumRegs-1:0] set_vec;

  assign set_vec = alloc_i ? (NumRegs'(1) << alloc_addr_i) : '0;

  // A new producer allocated in the same cycle as a write keeps the bit set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~clr_i) | set_vec;
    end
  end

  always_comb begin
    pend_o = '0;
    for (int r = 0; r < NumReadPorts; r++) begin
      if (int'(raddr_i[5*r +: 5]) < NumRegs) begin
        pend_o[r] = pend_q[raddr_i[5*r +: AddrW]];
      end
    end
  end

endmodule

// File: rtl/ibex_register_file_ff_mp.sv
// Multi-port flip-flop register file with write-to-read bypass, pending scoreboard
// and an optional write-enable integrity checker.
module ibex_register_file_ff_mp
  import ibex_rf_pkg::*;
#(
  parameter bit                 RV32E         = 1'b0,
  parameter int                 DataWidth     = 32,
  parameter int                 NumReadPorts  = 2,
  parameter int                 NumWritePorts = 2,
  parameter int                 Bypass        = 1,
  parameter int                 WrenCheck     = 0,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [5*NumReadPorts-1:0]          raddr_i,
  output logic [DataWidth*NumReadPorts-1:0]  rdata_o,
  output logic [NumReadPorts-1:0]            busy_o,
  input  logic [5*NumWritePorts-1:0]         waddr_i,
  input  logic [DataWidth*NumWritePorts-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]           we_i,
  input  logic                               alloc_i,
  input  rf_addr_t                           alloc_addr_i,
  output logic                               err_o
);

  localparam int NumRegs = num_regs(RV32E);
  localparam int AddrW   = $clog2(NumRegs);

  function automatic logic addr_ok(input rf_addr_t a);
    return (a != '0) && (int'(a) < NumRegs);
  endfunction

  logic [DataWidth-1:0]                   rf_q    [NumRegs];
  logic [DataWidth-1:0]                   wr_data [NumRegs];
  logic [NumWritePorts-1:0][NumRegs-1:0]  we_dec;
  logic [NumWritePorts-1:0]               wr_ok;
  logic [NumRegs-1:0]                     we_vec_d;
  logic [NumRegs-1:0]                     we_vec;
  logic [NumReadPorts-1:0]                rd_ok;
  logic [NumReadPorts-1:0]                rd_hit;
  logic [NumReadPorts-1:0]                pend;

  always_comb begin
    we_dec   = '0;
    wr_ok    = '0;
    we_vec_d = '0;
    for (int w = 0; w < NumWritePorts; w++) begin
      wr_ok[w] = we_i[w] & addr_ok(waddr_i[5*w +: 5]);
      for (int i = 0; i < NumRegs; i++) begin
        if (wr_ok[w] && (int'(waddr_i[5*w +: 5]) == i)) begin
          we_dec[w][i] = 1'b1;
        end
      end
      we_vec_d = we_vec_d | we_dec[w];
    end
  end

  // Kept as a separate net so the integrity checker sees exactly what drives the flops.
  assign we_vec = we_vec_d;

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      wr_data[i] = wdata_i[0 +: DataWidth];
      for (int w = 0; w < NumWritePorts; w++) begin
        if (we_dec[w][i]) begin
          wr_data[i] = wdata_i[DataWidth*w +: DataWidth];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= WordZeroVal;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        if (we_vec[i]) begin
          rf_q[i] <= wr_data[i];
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    rd_ok   = '0;
    rd_hit  = '0;
    for (int r = 0; r < NumReadPorts; r++) begin
      rd_ok[r] = addr_ok(raddr_i[5*r +: 5]);
      rdata_o[DataWidth*r +: DataWidth] = rf_q[raddr_i[5*r +: AddrW]];
      for (int w = 0; w < NumWritePorts; w++) begin
        if (wr_ok[w] && (waddr_i[5*w +: 5] == raddr_i[5*r +: 5])) begin
          rd_hit[r] = 1'b1;
          if (Bypass != 0) begin
            rdata_o[DataWidth*r +: DataWidth] = wdata_i[DataWidth*w +: DataWidth];
          end
        end
      end
      if (!rd_ok[r]) begin
        rdata_o[DataWidth*r +: DataWidth] = WordZeroVal;
      end
    end
  end

  ibex_rf_scoreboard #(
    .NumRegs      (NumRegs),
    .NumReadPorts (NumReadPorts)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alloc_i      (alloc_i & addr_ok(alloc_addr_i)),
    .alloc_addr_i (alloc_addr_i),
    .clr_i        (we_vec),
    .raddr_i      (raddr_i),
    .pend_o       (pend)
  );

  assign busy_o = rd_ok & pend & ~(((Bypass != 0) ? {NumReadPorts{1'b1}} : '0) & rd_hit);

  if (WrenCheck != 0) begin : g_wren_check
    logic [NumRegs-1:0] we_ref;
    logic               err_q;

    // Reference decode built with a shift instead of the compare loop above.
    always_comb begin
      we_ref = '0;
      for (int w = 0; w < NumWritePorts; w++) begin
        if (we_i[w] && (waddr_i[5*w +: 5] != 5'd0) && (int'(waddr_i[5*w +: 5]) < NumRegs)) begin
          we_ref = we_ref | (NumRegs'(1) << waddr_i[5*w +: 5]);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        err_q <= 1'b0;
      end else if (we_ref != we_vec) begin
        err_q <= 1'b1;
      end
    end

    assign err_o = err_q;
  end else begin : g_no_wren_check
    assign err_o = 1'b0;
  end

endmodule
